// File: rtl/line_fill_buffer.sv
// line_fill_buffer: single-entry write-back line buffer with miss fetch and write merge.
// Optional flush/flush_done ports when LINE_FILL_BUFFER_FLUSH_EN is defined.
module line_fill_buffer #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [15:0]           mem_wdata,
    input  logic [1:0]            mem_byte_enable,
    output logic                  mem_resp,
    output logic [(8<<OFFSET_W)-1:0] line_out,
    output logic [OFFSET_W-1:0]   offset_out,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_W-1:0]     pmem_address,
    output logic [(8<<OFFSET_W)-1:0] pmem_wdata,
    input  logic [(8<<OFFSET_W)-1:0] pmem_rdata,
    input  logic                  pmem_resp
`ifdef LINE_FILL_BUFFER_FLUSH_EN
    ,
    input  logic                  flush,
    output logic                  flush_done
`endif
);
    localparam int TAG_W  = ADDR_W - OFFSET_W;
    localparam int LINE_W = 8 << OFFSET_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t                state;
    logic                  valid, dirty;
    logic [TAG_W-1:0]      tag, req_tag;
    logic [LINE_W-1:0]     line;
    logic                  req, hit, idle_hit;
    logic [OFFSET_W+2:0]   lo_base, hi_base;

    assign req        = mem_read | mem_write;
    assign hit        = valid && (tag == mem_address[ADDR_W-1:OFFSET_W]);
    assign idle_hit   = (state == IDLE) && req && hit;
    assign line_out   = line;
    assign pmem_wdata = line;
    assign offset_out = mem_address[OFFSET_W-1:0];
    assign lo_base    = {mem_address[OFFSET_W-1:1], 4'b0000};
    assign hi_base    = {mem_address[OFFSET_W-1:1], 4'b1000};

`ifdef LINE_FILL_BUFFER_FLUSH_EN
    logic flush_pend, flushing, flush_go;
    // A pending flush is served before any new CPU request once back in IDLE
    assign flush_go = flush_pend | (flush & ~req);
    assign mem_resp = idle_hit & ~flush_go;
`else
    assign mem_resp = idle_hit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            valid        <= 1'b0;
            dirty        <= 1'b0;
            tag          <= '0;
            req_tag      <= '0;
            line         <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
`ifdef LINE_FILL_BUFFER_FLUSH_EN
            flush_pend   <= 1'b0;
            flushing     <= 1'b0;
            flush_done   <= 1'b0;
`endif
        end else begin
`ifdef LINE_FILL_BUFFER_FLUSH_EN
            flush_done <= 1'b0;
            if (flush && (state != IDLE || req))
                flush_pend <= 1'b1;
`endif
            case (state)
                IDLE: begin
`ifdef LINE_FILL_BUFFER_FLUSH_EN
                    if (flush_go) begin
                        flush_pend <= 1'b0;
                        if (dirty) begin
                            flushing     <= 1'b1;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag, {OFFSET_W{1'b0}}};
                            state        <= WRITEBACK;
                        end else begin
                            valid      <= 1'b0;
                            flush_done <= 1'b1;
                        end
                    end else
`endif
                    if (req) begin
                        if (hit) begin
                            if (mem_write) begin
                                if (mem_byte_enable[0]) line[lo_base +: 8] <= mem_wdata[7:0];
                                if (mem_byte_enable[1]) line[hi_base +: 8] <= mem_wdata[15:8];
                                dirty <= 1'b1;
                            end
                        end else begin
                            req_tag <= mem_address[ADDR_W-1:OFFSET_W];
                            if (dirty) begin
                                pmem_write   <= 1'b1;
                                pmem_address <= {tag, {OFFSET_W{1'b0}}};
                                state        <= WRITEBACK;
                            end else begin
                                pmem_read    <= 1'b1;
                                pmem_address <= {mem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                                state        <= FETCH;
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty      <= 1'b0;
                        pmem_write <= 1'b0;
`ifdef LINE_FILL_BUFFER_FLUSH_EN
                        if (flushing) begin
                            flushing   <= 1'b0;
                            valid      <= 1'b0;
                            flush_done <= 1'b1;
                            state      <= IDLE;
                        end else
`endif
                        begin
                            pmem_read    <= 1'b1;
                            pmem_address <= {req_tag, {OFFSET_W{1'b0}}};
                            state        <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // Install even if the CPU has since dropped its request
                    if (pmem_resp) begin
                        line      <= pmem_rdata;
                        tag       <= req_tag;
                        valid     <= 1'b1;
                        pmem_read <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_fill_buffer.sv
// tb_line_fill_buffer: scoreboard bench comparing the line buffer against a coherent memory model.
module tb_line_fill_buffer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  mem_address = '0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [15:0]  mem_wdata = '0;
    logic [1:0]   mem_byte_enable = '0;
    logic         mem_resp;
    logic [127:0] line_out;
    logic [3:0]   offset_out;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
`ifdef LINE_FILL_BUFFER_FLUSH_EN
    logic         flush = 1'b0;
    logic         flush_done;
`endif

    always #5 clk = ~clk;

    line_fill_buffer dut (
        .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .line_out(line_out), .offset_out(offset_out),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef LINE_FILL_BUFFER_FLUSH_EN
        , .flush(flush), .flush_done(flush_done)
`endif
    );

    typedef struct {logic [127:0] line; logic [3:0] off;} exp_t;

    int compared = 0, mismatched = 0;
    logic [127:0] backing [4096];
    logic [127:0] shadow  [4096];
    exp_t         sb [$];
    logic [16:0]  log_q [$];
    int  n_rd = 0, n_wr = 0, lat = 2;
    bit  mem_en = 1, rand_lat = 0;
    bit  res_valid = 0, res_dirty = 0;
    logic [11:0] res_tag = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every CPU response must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_resp) begin
                if (sb.size() == 0) chk("unexpected_resp", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("line_out", line_out, e.line);
                    chk("offset_out", offset_out, e.off);
                end
            end
        end
    end

    // Physical memory: responds lat cycles after a request appears
    initial begin
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                pmem_resp = 1'b0;
                if (pmem_read || pmem_write) chk("pmem_overlap", pmem_read & pmem_write, 0);
                if (!rst_n || !(pmem_read || pmem_write)) wcnt = 0;
                else if (wcnt < lat) wcnt++;
                else begin
                    wcnt = 0;
                    pmem_resp = 1'b1;
                    chk("pmem_align", pmem_address[3:0], 0);
                    log_q.push_back({pmem_write, pmem_address});
                    if (pmem_write) begin
                        n_wr++;
                        chk("wb_data", pmem_wdata, shadow[pmem_address[15:4]]);
                        backing[pmem_address[15:4]] = pmem_wdata;
                    end else begin
                        n_rd++;
                        pmem_rdata = backing[pmem_address[15:4]];
                    end
                    if (rand_lat) lat = $urandom_range(0, 3);
                end
            end
        end
    end

    task automatic cpu(input logic [15:0] a, input bit rd, input bit wr,
                       input logic [15:0] wd, input logic [1:0] be);
        int t = 0, r0 = n_rd, w0 = n_wr, off;
        logic [11:0] tg = a[15:4];
        bit miss = !(res_valid && res_tag == tg);
        sb.push_back('{shadow[tg], a[3:0]});
        @(posedge clk); #1;
        mem_address = a; mem_read = rd; mem_write = wr; mem_wdata = wd; mem_byte_enable = be;
        do begin @(negedge clk); t++; end while (!mem_resp && t < 500);
        if (!mem_resp) begin chk("resp_timeout", 0, 1); sb.delete(); end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        off = {a[3:1], 1'b0};
        if (wr) for (int b = 0; b < 2; b++)
            if (be[b]) shadow[tg][8*(off+b) +: 8] = wd[8*b +: 8];
        chk("pmem_reads", n_rd - r0, miss);
        chk("pmem_writes", n_wr - w0, miss && res_dirty);
        if (miss) begin res_valid = 1; res_tag = tg; res_dirty = 0; end
        if (wr) res_dirty = 1;
    endtask

    task automatic wait_pmem_read();
        int t = 0;
        do begin @(negedge clk); t++; end while (!pmem_read && t < 100);
        chk("pmem_read_seen", pmem_read, 1);
    endtask

    initial begin
        logic [11:0] tags [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
        int t;
        for (int i = 0; i < 4096; i++) begin
            backing[i] = {$urandom, $urandom, $urandom, $urandom};
            shadow[i] = backing[i];
        end
        backing[12'h123] = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        shadow[12'h123]  = backing[12'h123];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_line_out", line_out, 0);
        @(negedge clk) rst_n = 1;

        // Clean miss then hit
        cpu(16'h1236, 1, 0, 16'h0, 2'b00);
        chk("fetch_addr", log_q[$], {1'b0, 16'h1230});
        // Write-hit merge into word 2 low byte
        cpu(16'h1234, 0, 1, 16'hABCD, 2'b01);
        chk("merge_word2", line_out[47:32], 16'h22CD);
        // Dirty eviction: writeback first, then fetch
        log_q.delete();
        cpu(16'h4560, 1, 0, 16'h0, 2'b00);
        chk("evict_count", log_q.size(), 2);
        chk("evict_first", log_q[0], {1'b1, 16'h1230});
        chk("evict_second", log_q[1], {1'b0, 16'h4560});

        // Reset two cycles into a fetch, then a stray response
        lat = 8;
        @(posedge clk); #1;
        mem_address = 16'h2000; mem_read = 1;
        wait_pmem_read();
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("async_pmem_read", pmem_read, 0);
        chk("async_line_out", line_out, 0);
        mem_read = 0;
        for (int i = 0; i < 4096; i++) shadow[i] = backing[i];
        res_valid = 0; res_dirty = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        mem_en = 0;
        @(negedge clk); pmem_rdata = ~backing[12'h200]; pmem_resp = 1;
        @(negedge clk); pmem_resp = 0;
        @(negedge clk);
        chk("stray_resp_line", line_out, 0);
        mem_en = 1; lat = 2;
        cpu(16'h2000, 1, 0, 16'h0, 2'b00);

        // Drop the request mid-fetch; the line must still install
        t = n_rd;
        @(posedge clk); #1;
        mem_address = 16'h3008; mem_read = 1;
        wait_pmem_read();
        @(posedge clk); #1 mem_read = 0;
        for (int i = 0; i < 100 && n_rd == t; i++) @(negedge clk);
        chk("drop_fetch_done", n_rd - t, 1);
        res_valid = 1; res_tag = 12'h300; res_dirty = 0;
        cpu(16'h300A, 1, 0, 16'h0, 2'b00);

`ifdef LINE_FILL_BUFFER_FLUSH_EN
        cpu(16'h300C, 0, 1, 16'h5A5A, 2'b11);
        t = n_wr;
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        for (int i = 0; i < 100 && !flush_done; i++) @(negedge clk);
        chk("flush_done", flush_done, 1);
        chk("flush_wb", n_wr - t, 1);
        @(negedge clk);
        chk("flush_done_pulse", flush_done, 0);
        res_valid = 0; res_dirty = 0;
        cpu(16'h300C, 1, 0, 16'h0, 2'b00);
`endif

        // Randomized traffic over a few conflicting lines
        rand_lat = 1;
        repeat (300) begin
            logic [15:0] a = {tags[$urandom % 4], 4'($urandom)};
            int k = $urandom % 3;
            cpu(a, k != 1, k != 0, 16'($urandom), 2'($urandom));
        end

        repeat (4) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
